// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU front end.
package alu_arb_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0011;
  localparam logic [7:0] ERR_RESULT = 8'hFF;

  // Requests that never reach the ALU: unknown opcode or divide by zero.
  function automatic logic op_err(input logic [3:0] sel, input logic [7:0] b);
    return (sel > DIV) || ((sel == DIV) && (b == 8'h00));
  endfunction
endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two requesters and the arbiter.
interface alu_req_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_a;
  logic [1:0][7:0]  req_b;
  logic [1:0][3:0]  req_sel;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter_rr.sv
// Two-way round-robin picker: ptr names the requester favoured on a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters, one transaction at a time.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  alu_req_arbiter_if.slave   bus,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_sel,
  input  logic [7:0]         alu_out,
  input  logic               alu_carry
);
  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(ALU_LAT);

  state_t          state_q, state_d;
  logic            ptr_q, gid_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      res_q;
  logic            carry_q, err_q;
  logic [1:0]      grant;
  logic            win_id, accept, acc_err, done;
  logic [7:0]      a_in, b_in;
  logic [3:0]      sel_in;

  rr_arb2 u_rr (.valid(bus.req_valid), .ptr(ptr_q), .grant(grant));

  assign win_id  = grant[1];
  assign a_in    = bus.req_a[win_id];
  assign b_in    = bus.req_b[win_id];
  assign sel_in  = bus.req_sel[win_id];
  assign acc_err = op_err(sel_in, b_in);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (|grant) begin
        accept  = 1'b1;
        state_d = acc_err ? S_RESP : S_EXEC;
      end
      S_EXEC: if (cnt_q == LAST) begin
        done    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: if (bus.rsp_ready[gid_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE) ? grant : 2'b00;
  assign bus.rsp_valid  = (state_q == S_RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = res_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_err    = err_q;

  // ALU operands only move on a legal accept, so errored requests leave them untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 8'h00;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_sel <= 4'b0000;
    end else begin
      if (accept) begin
        gid_q <= win_id;
        ptr_q <= ~win_id;
        cnt_q <= '0;
        if (acc_err) begin
          res_q   <= ERR_RESULT;
          carry_q <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          alu_a   <= a_in;
          alu_b   <= b_in;
          alu_sel <= sel_in;
        end
      end
      if (state_q == S_EXEC) cnt_q <= cnt_q + CW'(1);
      if (done) begin
        res_q   <= alu_out;
        carry_q <= (alu_sel == ADD) & alu_carry;
        err_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;
  localparam int LAT = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_carry;
  int cyc = 0;
  int errors = 0, checks = 0;

  alu_req_arbiter_if bif();

  alu_req_arbiter #(.ALU_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bif),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Registered ALU stand-in; its carry is bit 8 for every op so masking is visible.
  logic [8:0] apipe [LAT];
  function automatic logic [8:0] alu_f(input logic [7:0] a, b, input logic [3:0] s);
    logic [15:0] p;
    case (s)
      4'd0: alu_f = {1'b0, a} + {1'b0, b};
      4'd1: alu_f = {1'b0, a} - {1'b0, b};
      4'd2: begin p = a * b; alu_f = p[8:0]; end
      4'd3: alu_f = (b == 0) ? 9'd0 : {1'b0, a / b};
      default: alu_f = 9'd0;
    endcase
  endfunction
  always @(posedge clock) begin
    apipe[0] <= alu_f(alu_a, alu_b, alu_sel);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign alu_out   = apipe[LAT-1][7:0];
  assign alu_carry = apipe[LAT-1][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_op(input logic [7:0] a, b, input logic [3:0] sel,
                          output logic [7:0] r, output logic c, output logic e);
    int x;
    e = (sel > 4'd3) || (sel == 4'd3 && b == 8'd0);
    c = 1'b0;
    r = 8'hFF;
    if (!e) begin
      case (sel)
        4'd0: begin x = int'(a) + int'(b); r = x[7:0]; c = (x > 255); end
        4'd1: begin x = int'(a) - int'(b); r = x[7:0]; end
        4'd2: begin x = int'(a) * int'(b); r = x[7:0]; end
        default: r = a / b;
      endcase
    end
  endtask

  // Model state: one outstanding transaction, its response cycle, and the favoured requester.
  logic       m_busy = 1'b0, m_ptr = 1'b0, m_gid = 1'b0;
  int         m_rsp_cyc = 0;
  logic [7:0] m_res = 8'h00, m_a = 8'h00, m_b = 8'h00;
  logic [3:0] m_sel = 4'h0;
  logic       m_carry = 1'b0, m_err = 1'b0;

  task automatic monitor();
    logic [1:0] v, exp_rdy;
    logic win, rsp_on;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_req_ready", bif.req_ready, 0);
        chk("rst_rsp_valid", bif.rsp_valid, 0);
        chk("rst_rsp_result", bif.rsp_result, 0);
        chk("rst_rsp_carry", bif.rsp_carry, 0);
        chk("rst_rsp_err", bif.rsp_err, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        m_busy = 0; m_ptr = 0; m_a = 0; m_b = 0; m_sel = 0;
      end else begin
        v = bif.req_valid;
        exp_rdy = 2'b00;
        win = 1'b0;
        if (!m_busy && v != 2'b00) begin
          win = (v == 2'b11) ? m_ptr : v[1];
          exp_rdy = win ? 2'b10 : 2'b01;
        end
        rsp_on = m_busy && (cyc >= m_rsp_cyc);
        chk("req_ready", bif.req_ready, exp_rdy);
        chk("rsp_valid", bif.rsp_valid, rsp_on ? (m_gid ? 2'b10 : 2'b01) : 2'b00);
        if (rsp_on) begin
          chk("rsp_result", bif.rsp_result, m_res);
          chk("rsp_carry", bif.rsp_carry, m_carry);
          chk("rsp_err", bif.rsp_err, m_err);
        end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_sel);
        if (rsp_on && bif.rsp_ready[m_gid]) m_busy = 0;
        else if (exp_rdy != 2'b00) begin
          m_busy = 1; m_gid = win; m_ptr = ~win;
          model_op(bif.req_a[win], bif.req_b[win], bif.req_sel[win], m_res, m_carry, m_err);
          m_rsp_cyc = cyc + (m_err ? 1 : LAT + 2);
          if (!m_err) begin
            m_a = bif.req_a[win]; m_b = bif.req_b[win]; m_sel = bif.req_sel[win];
          end
        end
      end
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, b, input logic [3:0] sel);
    bif.req_valid[id] = 1'b1;
    bif.req_a[id] = a;
    bif.req_b[id] = b;
    bif.req_sel[id] = sel;
  endtask

  task automatic wait_acc(input int id, output int acc);
    acc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bif.req_ready[id]) begin acc = cyc; break; end
    end
    chk("accept_seen", acc >= 0, 1);
    sync();
    bif.req_valid[id] = 1'b0;
  endtask

  task automatic issue(input int id, input logic [7:0] a, b, input logic [3:0] sel, output int acc);
    sync();
    set_req(id, a, b, sel);
    wait_acc(id, acc);
  endtask

  task automatic wait_rsp(input int id, input int acc, input int lat, input logic [7:0] er,
                          input logic ec, input logic ee, input int hold);
    int seen;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bif.rsp_valid[id]) begin seen = cyc; break; end
    end
    chk("rsp_latency", seen - acc, lat);
    chk("lit_result", bif.rsp_result, er);
    chk("lit_carry", bif.rsp_carry, ec);
    chk("lit_err", bif.rsp_err, ee);
    for (int h = 0; h < hold; h++) begin
      sync();
      if (h == 0) set_req(1 - id, 8'd1, 8'd1, ADD);
      @(negedge clock);
      chk("hold_result", bif.rsp_result, er);
      chk("hold_err", bif.rsp_err, ee);
      chk("hold_valid", bif.rsp_valid, (id == 1) ? 2'b10 : 2'b01);
      chk("hold_req_ready", bif.req_ready, 2'b00);
    end
    sync();
    if (hold > 0) bif.req_valid = 2'b00;
    bif.rsp_ready[id] = 1'b1;
    sync();
    bif.rsp_ready[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    sync();
    bif.req_valid = 2'b00;
    bif.rsp_ready = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    sync();
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    logic [5:0] order;
    bif.req_valid = '0; bif.req_a = '0; bif.req_b = '0; bif.req_sel = '0; bif.rsp_ready = '0;
    fork monitor(); join_none

    @(negedge clock);
    chk("reset_rsp_valid", bif.rsp_valid, 2'b00);
    chk("reset_alu_sel", alu_sel, 4'b0000);
    sync();
    reset = 1'b0;

    // add with carry out
    issue(0, 8'd200, 8'd100, ADD, acc);
    wait_rsp(0, acc, 3, 8'd44, 1'b1, 1'b0, 0);

    // simultaneous requests from reset: requester 0 first
    pulse_reset();
    set_req(0, 8'd10, 8'd3, SUB);
    set_req(1, 8'd16, 8'd17, MUL);
    @(negedge clock);
    chk("first_grant", bif.req_ready, 2'b01);
    acc = cyc;
    sync();
    bif.req_valid[0] = 1'b0;
    wait_rsp(0, acc, 3, 8'd7, 1'b0, 1'b0, 0);
    wait_acc(1, acc);
    wait_rsp(1, acc, 3, 8'h10, 1'b0, 1'b0, 0);

    // divide by zero bypasses the ALU
    issue(1, 8'd50, 8'd0, DIV, acc);
    wait_rsp(1, acc, 1, 8'hFF, 1'b0, 1'b1, 0);
    chk("div0_alu_sel_kept", alu_sel, 4'd2);
    chk("div0_alu_a_kept", alu_a, 8'd16);

    issue(0, 8'd3, 8'd10, SUB, acc);
    wait_rsp(0, acc, 3, 8'hF9, 1'b0, 1'b0, 0);
    issue(1, 8'd100, 8'd7, DIV, acc);
    wait_rsp(1, acc, 3, 8'd14, 1'b0, 1'b0, 0);
    issue(0, 8'd255, 8'd1, ADD, acc);
    wait_rsp(0, acc, 3, 8'd0, 1'b1, 1'b0, 0);

    // unsupported opcode, response back-pressured for 5 cycles
    issue(0, 8'd1, 8'd2, 4'b0101, acc);
    wait_rsp(0, acc, 1, 8'hFF, 1'b0, 1'b1, 5);

    // reset in the middle of EXEC drops the transaction
    issue(0, 8'd5, 8'd6, ADD, acc);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst_rsp_valid", bif.rsp_valid, 2'b00);
    chk("midrst_alu_a", alu_a, 8'd0);
    chk("midrst_alu_b", alu_b, 8'd0);
    sync();
    reset = 1'b0;
    issue(1, 8'd9, 8'd4, SUB, acc);
    wait_rsp(1, acc, 3, 8'd5, 1'b0, 1'b0, 0);

    // continuous contention alternates grants
    pulse_reset();
    set_req(0, 8'd1, 8'd1, ADD);
    set_req(1, 8'd2, 8'd2, ADD);
    bif.rsp_ready = 2'b11;
    n = 0;
    order = '0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clock);
      if (bif.req_ready != 2'b00) begin
        order[n] = bif.req_ready[1];
        n++;
      end
    end
    sync();
    bif.req_valid = 2'b00;
    chk("rr_count", n, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), order[k], k % 2);
    repeat (LAT + 5) sync();
    bif.rsp_ready = 2'b00;
    repeat (3) sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
